wb_queue: RTL

Writeback queue on the register-file write port. Accepts register-write requests from the pipeline's writeback stage, buffers them in a small in-order FIFO, and drains one entry per cycle onto the regfile's `we3`/`wa3`/`wd3` port whenever the port is not borrowed. With bypass compiled in, it also forwards the youngest pending value for the two read addresses, so decode never reads stale data while writes are queued.

---
 rtl/wb_queue.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback queue in front of the regfile write port.
// Requests from writeback are buffered in a DEPTH-entry FIFO and drained one
// per cycle onto we3/wa3/wd3 whenever no other writer holds the port.
// Optional feature macro: WBQ_BYPASS_EN adds youngest-match forwarding of
// pending values for the two read addresses (fwd1_*/fwd2_* ports).
// Without it the consumer must stall decode while the queue is non-empty.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4:0]                   in_addr,
  input  logic [31:0]                  in_data,
  input  logic                         port_busy,
  output logic                         we3,
  output logic [4:0]                   wa3,
  output logic [31:0]                  wd3,
  input  logic [4:0]                   ra1,
  input  logic [4:0]                   ra2,
`ifdef WBQ_BYPASS_EN
  output logic                         fwd1_hit,
  output logic                         fwd2_hit,
  output logic [31:0]                  fwd1_data,
  output logic [31:0]                  fwd2_data,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wbq_entry_t;

  wbq_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]          head_q, head_d;
  logic [AW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;

  logic push;   // handshake completes
  logic enq;    // handshake that actually stores an entry ($0 is dropped)
  logic pop;    // head entry goes to the regfile this cycle

  // Status flags come straight from the count register.
  always_comb begin
    count    = count_q;
    empty    = (count_q == '0);
    full     = (count_q == CNT_FULL);
    in_ready = !full;
  end

  // Handshake and drain decisions. in_ready ignores a same-cycle pop, so a
  // full queue never passes a request through.
  always_comb begin
    push = in_valid && in_ready;
    enq  = push && (in_addr != 5'd0);
    pop  = !empty && !port_busy;
  end

  // Regfile write port: head entry while draining, all zero otherwise.
  always_comb begin
    we3 = pop;
    wa3 = pop ? mem_q[head_q].addr : 5'd0;
    wd3 = pop ? mem_q[head_q].data : 32'd0;
  end

  // Next-state for storage, pointers and count. Pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      mem_d[tail_q] = '{addr: in_addr, data: in_data};
      tail_d        = tail_q + AW'(1);
    end
    if (pop) head_d = head_q + AW'(1);
    case ({enq, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards everything pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef WBQ_BYPASS_EN
  logic [DEPTH-1:0] slot_vld;
  logic [DEPTH-1:0] hit1_v;
  logic [DEPTH-1:0] hit2_v;

  for (genvar e = 0; e < DEPTH; e++) begin : g_slot
    logic [AW-1:0] age;
    // A physical slot is live when its distance from head is below count;
    // the head itself counts even while it is being written out.
    always_comb begin
      age         = AW'(e) - head_q;
      slot_vld[e] = ({1'b0, age} < count_q);
      hit1_v[e]   = slot_vld[e] && (mem_q[e].addr == ra1) && (ra1 != 5'd0);
      hit2_v[e]   = slot_vld[e] && (mem_q[e].addr == ra2) && (ra2 != 5'd0);
    end
  end

  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = 32'd0;
    fwd2_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit1_v[head_q + AW'(i)]) begin
        fwd1_hit  = 1'b1;
        fwd1_data = mem_q[head_q + AW'(i)].data;
      end
      if (hit2_v[head_q + AW'(i)]) begin
        fwd2_hit  = 1'b1;
        fwd2_data = mem_q[head_q + AW'(i)].data;
      end
    end
  end
`else
  logic unused_ra;
  // Read addresses only feed the lookup, which is not built here.
  always_comb unused_ra = ^{ra1, ra2};
`endif

endmodule
